// File: rtl/canny_pkg.sv
// Shared types and defaults for the Canny edge pipeline stages.
package canny_pkg;

    localparam int NBIT_MAG_DEF = 11;

    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_D0 = 2'd2,
        DIR_D1 = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } nms_state_e;

endpackage

// File: rtl/nms_line_buffer.sv
// One-row line buffer: combinational read and synchronous write at the same address.
module nms_line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 24
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign o_rdata = mem_q[i_addr];

    // Contents need no reset: row 0 and row 1 centres never use stale data.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/nms_stage.sv
// Canny non-maximum suppression: 3x3 window over a raster stream, keeps local maxima
// along the quantised gradient direction, and drains the pipeline at end of frame.
module nms_stage
    import canny_pkg::*;
#(
    parameter int NBIT_MAG = NBIT_MAG_DEF,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NBIT_MAG-1:0] i_mag,
    input  logic [1:0]          i_dir,
    output logic                o_valid,
    output logic [NBIT_MAG-1:0] o_mag,
    output logic                o_eof
);

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int DW  = $clog2(IMG_W + 2);
    localparam int LBW = 2 * NBIT_MAG + 2;

    localparam logic [CW-1:0] COL_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] COL_ONE    = CW'(1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_ONE    = RW'(1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [DW-1:0] DRN_ZERO   = {DW{1'b0}};
    localparam logic [DW-1:0] DRN_ONE    = DW'(1);
    localparam logic [DW-1:0] DRN_LAST   = DW'(IMG_W);
    localparam logic [NBIT_MAG-1:0] MAG_ZERO = {NBIT_MAG{1'b0}};

    typedef logic [2:0][2:0][NBIT_MAG-1:0] win_t;

    nms_state_e          state_q, state_d;
    logic [CW-1:0]       in_col_q, in_col_d;
    logic [RW-1:0]       in_row_q, in_row_d;
    logic [CW-1:0]       out_col_q, out_col_d;
    logic [RW-1:0]       out_row_q, out_row_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                ready_q, ready_d;
    logic [1:0]          dir_q, dir_d;
    win_t                win_q, win_d;
    logic                valid_q, valid_d;
    logic [NBIT_MAG-1:0] mag_q, mag_d;
    logic                eof_q, eof_d;

    logic                accept_s;
    logic                step_s;
    logic                emit_s;
    logic                border_s;
    logic [NBIT_MAG-1:0] pix_s;
    logic [1:0]          dir_in_s;
    logic [LBW-1:0]      lb_rdata_s;
    logic [LBW-1:0]      lb_wdata_s;
    logic [NBIT_MAG-1:0] mag_r1_s;
    logic [NBIT_MAG-1:0] mag_r2_s;
    logic [1:0]          lb_dir_s;
    logic [NBIT_MAG-1:0] nb_a_s;
    logic [NBIT_MAG-1:0] nb_b_s;
    logic [NBIT_MAG-1:0] kept_s;

    // Strict against the first neighbour, non-strict against the second, so a plateau keeps one pixel.
    function automatic logic keep_fn(input logic [NBIT_MAG-1:0] c,
                                     input logic [NBIT_MAG-1:0] a,
                                     input logic [NBIT_MAG-1:0] b);
        return (c > a) && (c >= b);
    endfunction

    // Each entry holds {dir of row-1, mag of row-2, mag of row-1} for one column.
    nms_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (LBW)
    ) u_line_buffer (
        .i_clk   (i_clk),
        .i_we    (step_s),
        .i_addr  (in_col_q),
        .i_wdata (lb_wdata_s),
        .o_rdata (lb_rdata_s)
    );

    // Input selection: real samples while filling/running, injected zeros while draining.
    always_comb begin
        accept_s   = i_valid && ready_q;
        step_s     = accept_s || (state_q == ST_DRAIN);
        if (state_q == ST_DRAIN) begin
            pix_s    = MAG_ZERO;
            dir_in_s = 2'b00;
        end else begin
            pix_s    = i_mag;
            dir_in_s = i_dir;
        end
        mag_r1_s   = lb_rdata_s[NBIT_MAG-1:0];
        mag_r2_s   = lb_rdata_s[2*NBIT_MAG-1:NBIT_MAG];
        lb_dir_s   = lb_rdata_s[LBW-1:2*NBIT_MAG];
        lb_wdata_s = {dir_in_s, mag_r1_s, pix_s};
    end

    // Window shift: column 2 is the newest column, row 0 the oldest row.
    always_comb begin
        win_d = win_q;
        if (step_s) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = mag_r2_s;
            win_d[1][2] = mag_r1_s;
            win_d[2][2] = pix_s;
        end else begin
            win_d = win_q;
        end
    end

    // Neighbour selection and suppression on the freshly shifted window.
    always_comb begin
        case (dir_e'(dir_q))
            DIR_H: begin
                nb_a_s = win_d[1][0];
                nb_b_s = win_d[1][2];
            end
            DIR_V: begin
                nb_a_s = win_d[0][1];
                nb_b_s = win_d[2][1];
            end
            DIR_D0: begin
                nb_a_s = win_d[0][0];
                nb_b_s = win_d[2][2];
            end
            DIR_D1: begin
                nb_a_s = win_d[0][2];
                nb_b_s = win_d[2][0];
            end
            default: begin
                nb_a_s = win_d[1][0];
                nb_b_s = win_d[1][2];
            end
        endcase
        border_s = (out_row_q == ROW_ZERO) || (out_row_q == ROW_LAST) ||
                   (out_col_q == COL_ZERO) || (out_col_q == COL_LAST);
        if (!border_s && keep_fn(win_d[1][1], nb_a_s, nb_b_s)) begin
            kept_s = win_d[1][1];
        end else begin
            kept_s = MAG_ZERO;
        end
    end

    // Sequencing: position counters, FILL/RUN/DRAIN control and output staging.
    always_comb begin
        state_d   = state_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        drain_d   = drain_q;
        ready_d   = ready_q;
        dir_d     = dir_q;
        emit_s    = 1'b0;
        valid_d   = 1'b0;
        mag_d     = MAG_ZERO;
        eof_d     = 1'b0;

        if (step_s) begin
            dir_d    = lb_dir_s;
            in_col_d = (in_col_q == COL_LAST) ? COL_ZERO : in_col_q + COL_ONE;
            emit_s   = (state_q != ST_FILL);
        end else begin
            dir_d = dir_q;
        end

        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    if (in_col_q == COL_LAST) begin
                        in_row_d = in_row_q + ROW_ONE;
                    end else begin
                        in_row_d = in_row_q;
                    end
                    if ((in_row_q == ROW_ONE) && (in_col_q == COL_ZERO)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_RUN: begin
                if (accept_s && (in_col_q == COL_LAST)) begin
                    if (in_row_q == ROW_LAST) begin
                        in_row_d = ROW_ZERO;
                        state_d  = ST_DRAIN;
                        ready_d  = 1'b0;
                        drain_d  = DRN_ZERO;
                    end else begin
                        in_row_d = in_row_q + ROW_ONE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_LAST) begin
                    state_d  = ST_FILL;
                    ready_d  = 1'b1;
                    in_col_d = COL_ZERO;
                    in_row_d = ROW_ZERO;
                    drain_d  = DRN_ZERO;
                end else begin
                    drain_d = drain_q + DRN_ONE;
                end
            end
            default: begin
                state_d = ST_FILL;
                ready_d = 1'b1;
            end
        endcase

        if (emit_s) begin
            valid_d = 1'b1;
            mag_d   = kept_s;
            eof_d   = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
            if (out_col_q == COL_LAST) begin
                out_col_d = COL_ZERO;
                out_row_d = (out_row_q == ROW_LAST) ? ROW_ZERO : out_row_q + ROW_ONE;
            end else begin
                out_col_d = out_col_q + COL_ONE;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and registered outputs; reset discards any partial frame immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_FILL;
            in_col_q  <= COL_ZERO;
            in_row_q  <= ROW_ZERO;
            out_col_q <= COL_ZERO;
            out_row_q <= ROW_ZERO;
            drain_q   <= DRN_ZERO;
            ready_q   <= 1'b1;
            dir_q     <= 2'b00;
            win_q     <= {(9 * NBIT_MAG){1'b0}};
            valid_q   <= 1'b0;
            mag_q     <= MAG_ZERO;
            eof_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            drain_q   <= drain_d;
            ready_q   <= ready_d;
            dir_q     <= dir_d;
            win_q     <= win_d;
            valid_q   <= valid_d;
            mag_q     <= mag_d;
            eof_q     <= eof_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_mag   = mag_q;
    assign o_eof   = eof_q;

endmodule

// File: tb/tb_nms_stage.sv
// Directed table-driven bench for nms_stage on an 8x6 frame.
module tb_nms_stage;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int N    = 11;
    localparam int NPIX = W * H;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [N-1:0] i_mag = '0;
    logic [1:0]   i_dir = 2'b00;
    logic         o_ready;
    logic         o_valid;
    logic [N-1:0] o_mag;
    logic         o_eof;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc10_cyc = -1;
    int first_out_cyc = -1;
    int got_mag[$];
    bit got_eof[$];

    typedef struct {
        int         pat;
        logic [1:0] dir;
        bit         gaps;
        int         exp_nz;
    } vec_t;

    vec_t vecs[10];

    nms_stage #(.NBIT_MAG(N), .IMG_W(W), .IMG_H(H)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mag   (i_mag),
        .i_dir   (i_dir),
        .o_valid (o_valid),
        .o_mag   (o_mag),
        .o_eof   (o_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (got_mag.size() == 0) first_out_cyc = cyc;
            got_mag.push_back(int'(o_mag));
            got_eof.push_back(o_eof);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pix(input int pat, input logic [1:0] dir, input int r, input int c);
        case (pat)
            0: return 100;
            1: return (c == 3) ? 500 : 10;
            2: return (r == 2 && c == 4) ? 900 : 200;
            default: begin
                if (dir == 2'd2) begin
                    if ((r == 1 && c == 1) || (r == 2 && c == 2)) return 300;
                    if (r == 3 && c == 3) return 100;
                end else begin
                    if ((r == 2 && c == 2) || (r == 3 && c == 1)) return 300;
                    if (r == 1 && c == 3) return 100;
                end
                return 0;
            end
        endcase
        return 0;
    endfunction

    // Hand-derived survivors for each pattern.
    function automatic int exp_out(input int pat, input logic [1:0] dir, input int r, input int c);
        case (pat)
            0: return 0;
            1: return (r >= 1 && r <= 4 && c == 3) ? 500 : 0;
            2: return (r == 2 && c == 4) ? 900 : 0;
            default: begin
                if (dir == 2'd2) return (r == 1 && c == 1) ? 300 : 0;
                return (r == 2 && c == 2) ? 300 : 0;
            end
        endcase
        return 0;
    endfunction

    task automatic run_frame(input int t, input int pat, input logic [1:0] dir,
                             input bit gaps, input int n_send);
        int k = 0;
        int guard = 0;
        int rdy_low = 0;
        got_mag.delete();
        got_eof.delete();
        acc10_cyc = -1;
        first_out_cyc = -1;
        while (k < n_send && guard < 1000) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_valid = 1'b0;
            end else begin
                i_valid = 1'b1;
                i_mag   = N'(pix(pat, dir, k / W, k % W));
                i_dir   = dir;
                k++;
            end
            @(negedge clk);
            if (k == 10 && i_valid && acc10_cyc < 0) acc10_cyc = cyc;
        end
        i_valid = 1'b0;
        if (n_send == NPIX) begin
            while (!o_ready && rdy_low < 50) begin
                rdy_low++;
                @(negedge clk);
            end
            check($sformatf("t%0d_ready_low_cycles", t), rdy_low, W + 1);
            repeat (3) @(negedge clk);
            check($sformatf("t%0d_first_output_cycle", t), first_out_cyc, acc10_cyc);
        end
    endtask

    task automatic verify(input int t, input int pat, input logic [1:0] dir, input int exp_nz);
        int nz = 0;
        int eofs = 0;
        int eof_at = -1;
        check($sformatf("t%0d_output_count", t), got_mag.size(), NPIX);
        for (int i = 0; i < got_mag.size() && i < NPIX; i++) begin
            check($sformatf("t%0d_mag_r%0d_c%0d", t, i / W, i % W), got_mag[i],
                  exp_out(pat, dir, i / W, i % W));
            if (got_mag[i] != 0) nz++;
            if (got_eof[i]) begin
                eofs++;
                eof_at = i;
            end
        end
        check($sformatf("t%0d_nonzero_count", t), nz, exp_nz);
        check($sformatf("t%0d_eof_count", t), eofs, 1);
        check($sformatf("t%0d_eof_index", t), eof_at, NPIX - 1);
    endtask

    initial begin
        vecs[0] = '{0, 2'd0, 1'b0, 0};
        vecs[1] = '{1, 2'd0, 1'b0, 4};
        vecs[2] = '{2, 2'd0, 1'b0, 1};
        vecs[3] = '{2, 2'd1, 1'b0, 1};
        vecs[4] = '{2, 2'd2, 1'b0, 1};
        vecs[5] = '{2, 2'd3, 1'b0, 1};
        vecs[6] = '{3, 2'd2, 1'b0, 1};
        vecs[7] = '{3, 2'd3, 1'b0, 1};
        vecs[8] = '{1, 2'd0, 1'b1, 4};
        vecs[9] = '{2, 2'd1, 1'b1, 1};

        repeat (2) @(negedge clk);
        check("reset_o_valid", int'(o_valid), 0);
        check("reset_o_mag",   int'(o_mag),   0);
        check("reset_o_eof",   int'(o_eof),   0);
        check("reset_o_ready", int'(o_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 10; t++) begin
            run_frame(t, vecs[t].pat, vecs[t].dir, vecs[t].gaps, NPIX);
            verify(t, vecs[t].pat, vecs[t].dir, vecs[t].exp_nz);
        end

        // Reset in the middle of row 3, then a clean frame.
        run_frame(10, 1, 2'd0, 1'b0, 3 * W + 4);
        check("midreset_valid_before", int'(o_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async_o_valid", int'(o_valid), 0);
        check("midreset_async_o_ready", int'(o_ready), 1);
        check("midreset_async_o_mag",   int'(o_mag),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(11, 1, 2'd0, 1'b0, NPIX);
        verify(11, 1, 2'd0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
